button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Upstream front end for the stopwatch control FSM.
- Takes three raw, asynchronous, bouncing push-button inputs (start, stop, reset) and synchronises and debounces each one.
- Emits mutually exclusive single-cycle press pulses that drive the FSM's start/stop/reset inputs directly.
- Also exports debounced button levels for display/diagnostics.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a level change; legal range >= 2.
- LONG_PRESS_CYCLES, 2000000: hold time on stop that generates a reset pulse; used only with LONG_PRESS_RESET_EN; must be > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; synchronous, active-low
- btn_start_raw  input  1  raw start button, asynchronous, active-high
- btn_stop_raw  input  1  raw stop button, asynchronous, active-high
- btn_reset_raw  input  1  raw reset button, asynchronous, active-high
- start  output  1  one-cycle press pulse, to FSM start
- stop  output  1  one-cycle press pulse, to FSM stop
- reset  output  1  one-cycle press pulse, to FSM reset
- btn_level  output  3  debounced levels: {reset, stop, start}

Behaviour:
- Reset: on any clk edge with rst_n=0, the following clear to 0: sync flops, debounced levels, debounce counters, long-press counter/flag, and all outputs (start, stop, reset, btn_level).
- Per channel, identical logic:
  - Synchroniser: 2-flop chain s1 -> s2; no logic between the flops.
  - Debounce counter: width $clog2(DEBOUNCE_CYCLES+1).
    - Edge where s2 != db and cnt == DEBOUNCE_CYCLES-1: db <= s2, cnt <= 0.
    - Edge where s2 != db otherwise: cnt <= cnt+1.
    - Edge where s2 == db: cnt <= 0. Any glitch shorter than DEBOUNCE_CYCLES is fully rejected and the count restarts.
  - Press event: raised on the same edge where db goes 0->1. Release (db 1->0) raises no event.
- Latency: raw=1 first sampled at edge 0 and held stable -> pulse and btn_level bit are high after edge DEBOUNCE_CYCLES+1. The pulse lasts exactly one cycle; the level stays high until release is accepted.
- Priority: if more than one press event occurs on the same edge, only the highest is output: reset > stop > start. Suppressed events are dropped, not queued. At most one of start/stop/reset is high in any cycle.
- All outputs are registered; no combinational path from raw inputs to outputs.
- Button held through reset release: db restarts at 0, so a held button produces a fresh press pulse DEBOUNCE_CYCLES+2 edges after rst_n returns high (2 sync + debounce).
- Holding a button produces no further pulses until it is released and pressed again.

Optional Feature:
- Macro: LONG_PRESS_RESET_EN.
- Defined:
  - A long-press counter runs while db_stop=1, starting at 0 on the stop-press edge.
  - When it reaches LONG_PRESS_CYCLES, one reset pulse is emitted (priority rules apply) and a latch flag is set.
  - No further long-press pulses occur until db_stop returns to 0, which clears the counter and the flag.
  - The counter saturates at LONG_PRESS_CYCLES.
- Undefined: no long-press logic; stop behaves as a plain button.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16):
- Clean press: btn_start_raw 0->1 sampled at edge 0, held 20 cycles -> start=1 only in the cycle after edge 5; btn_level=3'b001 from edge 5 until release is accepted; stop=reset=0 throughout.
- Bounce rejection: btn_stop_raw toggles 1,0,1,0 (3-cycle high, 1-cycle low) then steady 1 -> no pulse during bouncing; exactly one stop pulse 5 edges after the steady-1 run first reaches s1.
- Simultaneous: start and reset raw rise on the same edge and are held -> reset pulses once, start never pulses; btn_level=3'b101.
- Release: after an accepted press, raw drops to 0 -> btn_level bit clears 5 edges later; no pulse on any output.
- Mid-operation reset: rst_n=0 while debounce cnt=2 and btn_start_raw held -> all outputs 0 the following cycle; after rst_n=1, start pulses once 6 edges later.
- LONG_PRESS_RESET_EN defined, stop held 40 cycles -> one stop pulse, then exactly one reset pulse 16 cycles after the stop pulse, no further pulses; without the macro -> stop pulse only.

Source files
------------

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Front end for the stopwatch control FSM. Three raw, asynchronous, bouncing
// push buttons (start, stop, reset) are each synchronised with a two-flop
// chain and debounced. Each accepted press becomes a single-cycle pulse on
// start/stop/reset. These pulses never overlap: reset beats stop beats start,
// and a losing press on the same edge is dropped. The debounced levels are
// also exported for display and diagnostics.
//
// Optional feature (macro LONG_PRESS_RESET_EN):
//   Holding stop for LONG_PRESS_CYCLES cycles after its press emits one reset
//   pulse. No further long-press pulse is issued until stop is released.
//
// Ports:
//   clk            in   system clock
//   rst_n          in   synchronous, active-low reset
//   btn_start_raw  in   raw start button (async, active-high)
//   btn_stop_raw   in   raw stop button  (async, active-high)
//   btn_reset_raw  in   raw reset button (async, active-high)
//   start          out  one-cycle press pulse to FSM start
//   stop           out  one-cycle press pulse to FSM stop
//   reset          out  one-cycle press pulse to FSM reset
//   btn_level[2:0] out  debounced levels {reset, stop, start}
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned LONG_PRESS_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_raw,
  input  logic       btn_stop_raw,
  input  logic       btn_reset_raw,
  output logic       start,
  output logic       stop,
  output logic       reset,
  output logic [2:0] btn_level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Parameter legality is checked at elaboration time.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long_press
    $error("button_conditioner: LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  // Channel index: 0 = start, 1 = stop, 2 = reset.
  logic [2:0] raw;
  logic [2:0] db_lvl;   // current debounced levels (flop outputs)
  logic [2:0] db_nxt;   // debounced levels after this edge
  logic [2:0] press;    // 0->1 transition of the debounced level on this edge

  assign raw = {btn_reset_raw, btn_stop_raw, btn_start_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic             s1_q;
      logic             s2_q;
      logic             db_q;
      logic             db_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // The counter only advances while the synchronised input disagrees with
      // the accepted level; any agreement restarts it, so a glitch shorter
      // than DEBOUNCE_CYCLES leaves no trace.
      always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
          if (cnt_q == CNT_LAST) begin
            db_d  = s2_q;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_q  <= 1'b0;
          s2_q  <= 1'b0;
          db_q  <= 1'b0;
          cnt_q <= '0;
        end else begin
          s1_q  <= raw[gi];
          s2_q  <= s1_q;
          db_q  <= db_d;
          cnt_q <= cnt_d;
        end
      end

      assign db_lvl[gi] = db_q;
      assign db_nxt[gi] = db_d;
    end
  endgenerate

  assign press = db_nxt & ~db_lvl;

  // Long-press reset request from the stop channel.
  logic lp_event;

`ifdef LONG_PRESS_RESET_EN
  localparam int unsigned LP_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_PRESS_CYCLES);

  logic [LP_W-1:0] lp_cnt_q;
  logic [LP_W-1:0] lp_cnt_d;
  logic            lp_flag_q;
  logic            lp_flag_d;
  logic            stop_held;

  // Stop counts as held only while it was and stays high across this edge.
  // The press edge therefore leaves the counter at 0, and the release edge
  // clears it without firing.
  assign stop_held = db_lvl[1] & db_nxt[1];

  always_comb begin
    lp_cnt_d  = '0;
    lp_flag_d = 1'b0;
    lp_event  = 1'b0;
    if (stop_held) begin
      lp_flag_d = lp_flag_q;
      lp_cnt_d  = (lp_cnt_q == LP_MAX) ? lp_cnt_q : lp_cnt_q + 1'b1;
      if (!lp_flag_q && (lp_cnt_d == LP_MAX)) begin
        lp_event  = 1'b1;
        lp_flag_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lp_cnt_q  <= '0;
      lp_flag_q <= 1'b0;
    end else begin
      lp_cnt_q  <= lp_cnt_d;
      lp_flag_q <= lp_flag_d;
    end
  end
`else
  assign lp_event = 1'b0;
`endif

  // Priority encode the events so at most one pulse is high per cycle.
  logic start_q, start_d;
  logic stop_q,  stop_d;
  logic reset_q, reset_d;

  always_comb begin
    reset_d = press[2] | lp_event;
    stop_d  = press[1] & ~reset_d;
    start_d = press[0] & ~reset_d & ~press[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      reset_q <= 1'b0;
    end else begin
      start_q <= start_d;
      stop_q  <= stop_d;
      reset_q <= reset_d;
    end
  end

  assign start     = start_q;
  assign stop      = stop_q;
  assign reset     = reset_q;
  assign btn_level = db_lvl;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4 and
// LONG_PRESS_CYCLES=16. Expected pulse/level timing is hand-derived: a raw
// level first sampled at edge 0 is accepted on edge 5. Define
// LONG_PRESS_RESET_EN for both DUT and bench to exercise the long-press path.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic       btn_start_raw;
  logic       btn_stop_raw;
  logic       btn_reset_raw;
  logic       start;
  logic       stop;
  logic       reset;
  logic [2:0] btn_level;

  int n_checks = 0;
  int n_bad    = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_start_raw (btn_start_raw),
    .btn_stop_raw  (btn_stop_raw),
    .btn_reset_raw (btn_reset_raw),
    .start         (start),
    .stop          (stop),
    .reset         (reset),
    .btn_level     (btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raw(input logic [2:0] v);
    btn_start_raw = v[0];
    btn_stop_raw  = v[1];
    btn_reset_raw = v[2];
  endtask

  // Hold 'raw' for 'hold' edges, expecting exp_pulse only after edge 5 and
  // exp_lvl from edge 5 on; then release and expect the level to fall on
  // edge 5 of the release with no pulses.
  task automatic press_case(input string name, input logic [2:0] raw,
                            input int hold, input logic [2:0] exp_pulse,
                            input logic [2:0] exp_lvl);
    set_raw(raw);
    for (int e = 0; e < hold; e++) begin
      step();
      check_val({name, "_pulse"}, {29'd0, reset, stop, start},
                {29'd0, (e == 5) ? exp_pulse : 3'b000});
      check_val({name, "_lvl"}, {29'd0, btn_level},
                {29'd0, (e >= 5) ? exp_lvl : 3'b000});
    end
    set_raw(3'b000);
    for (int e = 0; e < 10; e++) begin
      step();
      check_val({name, "_rel_pulse"}, {29'd0, reset, stop, start}, 32'd0);
      check_val({name, "_rel_lvl"}, {29'd0, btn_level},
                {29'd0, (e >= 5) ? 3'b000 : exp_lvl});
    end
    $display("case %s: raw=%b held %0d cycles, checks so far=%0d", name, raw, hold, n_checks);
  endtask

  initial begin
    logic [2:0] exp_p;

    // Reset with all buttons pressed: everything must stay cleared.
    rst_n = 1'b0;
    set_raw(3'b111);
    for (int i = 0; i < 3; i++) step();
    check_val("rst_start", {31'd0, start}, 32'd0);
    check_val("rst_stop",  {31'd0, stop},  32'd0);
    check_val("rst_reset", {31'd0, reset}, 32'd0);
    check_val("rst_level", {29'd0, btn_level}, 32'd0);
    $display("case reset: outputs checked under rst_n=0");
    set_raw(3'b000);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();

    // Clean presses, including the same-edge priority cases.
    press_case("clean_start", 3'b001, 20, 3'b001, 3'b001);
    press_case("start_reset", 3'b101, 12, 3'b100, 3'b101);
    press_case("start_stop",  3'b011, 12, 3'b010, 3'b011);

    // Bounce on stop: two 3-cycle highs (one short of acceptance) separated
    // by single low cycles, then steady high from edge 8.
    for (int e = 0; e < 20; e++) begin
      btn_stop_raw = !(e == 3 || e == 7);
      step();
      check_val("bounce_pulse", {29'd0, reset, stop, start},
                {29'd0, (e == 13) ? 3'b010 : 3'b000});
      check_val("bounce_lvl", {29'd0, btn_level},
                {29'd0, (e >= 13) ? 3'b010 : 3'b000});
    end
    btn_stop_raw = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step();
      check_val("bounce_rel_pulse", {29'd0, reset, stop, start}, 32'd0);
    end
    $display("case bounce: stop accepted on edge 13");

    // Reset while the start debounce counter sits at 2.
    btn_start_raw = 1'b1;
    for (int e = 0; e < 4; e++) step();
    rst_n = 1'b0;
    step();
    check_val("midrst_pulse", {29'd0, reset, stop, start}, 32'd0);
    check_val("midrst_lvl", {29'd0, btn_level}, 32'd0);
    rst_n = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      step();
      check_val("midrst_after_pulse", {29'd0, reset, stop, start},
                {29'd0, (r == 6) ? 3'b001 : 3'b000});
      check_val("midrst_after_lvl", {29'd0, btn_level},
                {29'd0, (r >= 6) ? 3'b001 : 3'b000});
    end
    btn_start_raw = 1'b0;
    for (int e = 0; e < 10; e++) step();
    check_val("midrst_rel_lvl", {29'd0, btn_level}, 32'd0);
    $display("case mid_reset: start re-pressed 6 edges after release of rst_n");

    // Reset while stop is accepted and held: level must drop, then a fresh
    // press follows release of rst_n.
    btn_stop_raw = 1'b1;
    for (int e = 0; e < 8; e++) step();
    check_val("heldrst_pre_lvl", {29'd0, btn_level}, 32'd2);
    rst_n = 1'b0;
    step();
    check_val("heldrst_lvl", {29'd0, btn_level}, 32'd0);
    rst_n = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      step();
      check_val("heldrst_after_pulse", {29'd0, reset, stop, start},
                {29'd0, (r == 6) ? 3'b010 : 3'b000});
    end
    btn_stop_raw = 1'b0;
    for (int e = 0; e < 10; e++) step();
    $display("case held_reset: stop re-pressed after reset");

    // Long hold on stop.
    btn_stop_raw = 1'b1;
    for (int e = 0; e < 40; e++) begin
      step();
      exp_p = (e == 5) ? 3'b010 : 3'b000;
`ifdef LONG_PRESS_RESET_EN
      if (e == 21) exp_p = 3'b100;
`endif
      check_val("long_pulse", {29'd0, reset, stop, start}, {29'd0, exp_p});
      check_val("long_lvl", {29'd0, btn_level},
                {29'd0, (e >= 5) ? 3'b010 : 3'b000});
    end
    btn_stop_raw = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step();
      check_val("long_rel_pulse", {29'd0, reset, stop, start}, 32'd0);
    end
    $display("case long_press: stop held 40 cycles");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
